// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV64 core.
// Turns load-use hazards, taken branches and the data-memory handshake
// into per-stage load enables, flushes and a MEM/WB bubble, tracks how
// long the pipeline has been waiting on data memory, and counts stall
// and flush events.
//
// state     | meaning
// ----------+------------------------------------------------------------
// RUN       | normal issue; hazards resolved by stall or flush
// MEM_WAIT  | data memory has not answered yet; wait_q counts freeze cycles
// ERROR     | memory timed out; pipeline frozen until reset
module pipeline_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             exmem_branch_taken,
  input  logic             exmem_mem_req,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // The wait counter is 8 bits, so the timeout limit is truncated to match.
  localparam logic [7:0] TIMEOUT_LIM = 8'(MEM_TIMEOUT);

  state_t           state_q;
  state_t           state_d;
  logic [7:0]       wait_q;
  logic [7:0]       wait_d;
  logic             mem_error_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic             load_use;
  logic             mem_pending;
  logic             stall_evt;
  logic             flush_evt;
  logic             err_set;

  // Hazard detection: load in EX whose destination is read by the ID instruction.
  always_comb begin
    load_use    = idex_MemRead && (idex_rd != 5'd0) &&
                  ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    mem_pending = exmem_mem_req && !dmem_ready;
  end

  // Next-state, wait-counter and control-output decode, priority ERROR > freeze > branch > load-use.
  always_comb begin
    pc_write      = 1'b1;
    pc_sel_branch = 1'b0;
    ifid_write    = 1'b1;
    ifid_flush    = 1'b0;
    idex_write    = 1'b1;
    idex_flush    = 1'b0;
    exmem_write   = 1'b1;
    exmem_flush   = 1'b0;
    memwb_bubble  = 1'b0;
    state_d       = state_q;
    wait_d        = wait_q;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    err_set       = 1'b0;

    if (reset) begin
      // Hold everything and drain every stage to a NOP while in reset.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      idex_write   = 1'b0;
      exmem_write  = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
      state_d      = ST_RUN;
      wait_d       = 8'd0;
    end else begin
      case (state_q)
        ST_ERROR: begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_write  = 1'b0;
          memwb_bubble = 1'b1;
          stall_evt    = 1'b1;
        end

        default: begin
          if (mem_pending) begin
            // Freeze: nothing advances and MEM/WB must not retire the
            // stalled access twice. Branches and load-use wait their turn.
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            stall_evt    = 1'b1;
            if (state_q == ST_RUN) begin
              state_d = ST_MEM_WAIT;
              wait_d  = 8'd1;
            end else if (wait_q == TIMEOUT_LIM) begin
              state_d = ST_ERROR;
              err_set = 1'b1;
            end else begin
              wait_d = wait_q + 8'd1;
            end
          end else begin
            state_d = ST_RUN;
            wait_d  = 8'd0;
            if (exmem_branch_taken) begin
              // Taken branch squashes the three younger instructions;
              // a coincident load-use stall is moot since ID is flushed.
              pc_sel_branch = 1'b1;
              ifid_flush    = 1'b1;
              idex_flush    = 1'b1;
              exmem_flush   = 1'b1;
              flush_evt     = 1'b1;
            end else if (load_use) begin
              // One bubble into EX; the flushed ID/EX drops MemRead, so
              // the hazard clears by itself next cycle.
              pc_write   = 1'b0;
              ifid_write = 1'b0;
              idex_flush = 1'b1;
              stall_evt  = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // State, wait counter, sticky error and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      wait_q      <= 8'd0;
      mem_error_q <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (err_set) begin
        mem_error_q <= 1'b1;
      end
      if (stall_evt) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_evt) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  // Registered status outputs.
  always_comb begin
    mem_error = mem_error_q;
    stall_cnt = stall_cnt_q;
    flush_cnt = flush_cnt_q;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a short memory timeout.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 32;

  // {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write,
  //  idex_flush, exmem_write, exmem_flush, memwb_bubble}
  localparam logic [8:0] C_RST = 9'b000101011;
  localparam logic [8:0] C_DEF = 9'b101010100;
  localparam logic [8:0] C_FRZ = 9'b000000001;
  localparam logic [8:0] C_BR  = 9'b111111110;
  localparam logic [8:0] C_LU  = 9'b000011100;

  logic             clk = 1'b0;
  logic             reset;
  logic             idex_MemRead;
  logic [4:0]       idex_rd;
  logic [4:0]       ifid_rs1;
  logic [4:0]       ifid_rs2;
  logic             exmem_branch_taken;
  logic             exmem_mem_req;
  logic             dmem_ready;
  logic             pc_write;
  logic             pc_sel_branch;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_write;
  logic             idex_flush;
  logic             exmem_write;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [8:0]       ctrl;

  int total = 0;
  int bad   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .idex_MemRead(idex_MemRead), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .exmem_branch_taken(exmem_branch_taken),
    .exmem_mem_req(exmem_mem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .pc_sel_branch(pc_sel_branch),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush),
    .exmem_write(exmem_write), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .mem_error(mem_error),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign ctrl = {pc_write, pc_sel_branch, ifid_write, ifid_flush, idex_write,
                 idex_flush, exmem_write, exmem_flush, memwb_bubble};

  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    idex_MemRead       = 1'b0;
    idex_rd            = 5'd0;
    ifid_rs1           = 5'd0;
    ifid_rs2           = 5'd0;
    exmem_branch_taken = 1'b0;
    exmem_mem_req      = 1'b0;
    dmem_ready         = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    step();
    step();
    total++; if (ctrl !== C_RST) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST); end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", mem_error); end
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    reset = 1'b0;
    #1;
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL default_ctrl got=%b exp=%b", ctrl, C_DEF); end
    step();
    total++; if (stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL idle_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    idex_MemRead = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; ifid_rs1 = 5'd3;
    #1;
    total++; if (ctrl !== C_LU) begin bad++; $display("FAIL lu_rs2_ctrl got=%b exp=%b", ctrl, C_LU); end
    step(); exp_stall++;
    clear_inputs();
    #1;
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL lu_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL lu_release_ctrl got=%b exp=%b", ctrl, C_DEF); end
    // x0 destination never creates a hazard
    idex_MemRead = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0;
    #1;
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL lu_x0_ctrl got=%b exp=%b", ctrl, C_DEF); end
    // match on rs1
    idex_rd = 5'd7; ifid_rs1 = 5'd7; ifid_rs2 = 5'd1;
    #1;
    total++; if (ctrl !== C_LU) begin bad++; $display("FAIL lu_rs1_ctrl got=%b exp=%b", ctrl, C_LU); end
    step(); exp_stall++;
    // register match without a load is not a hazard
    idex_MemRead = 1'b0;
    #1;
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL lu_noload_ctrl got=%b exp=%b", ctrl, C_DEF); end
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL lu_stall_cnt2 got=%0d exp=%0d", stall_cnt, exp_stall); end
    step();
  endtask

  task automatic test_branch();
    clear_inputs();
    exmem_branch_taken = 1'b1;
    #1;
    total++; if (ctrl !== C_BR) begin bad++; $display("FAIL br_ctrl got=%b exp=%b", ctrl, C_BR); end
    step(); exp_flush++;
    clear_inputs();
    #1;
    total++; if (flush_cnt !== exp_flush) begin bad++; $display("FAIL br_flush_cnt got=%0d exp=%0d", flush_cnt, exp_flush); end
    // branch wins over a coincident load-use hazard
    exmem_branch_taken = 1'b1; idex_MemRead = 1'b1; idex_rd = 5'd9; ifid_rs1 = 5'd9;
    #1;
    total++; if (ctrl !== C_BR) begin bad++; $display("FAIL br_lu_ctrl got=%b exp=%b", ctrl, C_BR); end
    step(); exp_flush++;
    clear_inputs();
    #1;
    total++; if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin bad++; $display("FAIL br_lu_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
  endtask

  task automatic test_mem_wait();
    clear_inputs();
    // ready in the same cycle as the request: no freeze
    exmem_mem_req = 1'b1; dmem_ready = 1'b1;
    #1;
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL mem_fast_ctrl got=%b exp=%b", ctrl, C_DEF); end
    step();
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctrl !== C_FRZ) begin bad++; $display("FAIL mem_frz%0d_ctrl got=%b exp=%b", i, ctrl, C_FRZ); end
      step(); exp_stall++;
    end
    dmem_ready = 1'b1;
    #1;
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL mem_release_ctrl got=%b exp=%b", ctrl, C_DEF); end
    step();
    clear_inputs();
    #1;
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL mem_stall_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    // release by dropping the request, load-use applies on the release cycle
    exmem_mem_req = 1'b1;
    step(); exp_stall++;
    exmem_mem_req = 1'b0; idex_MemRead = 1'b1; idex_rd = 5'd4; ifid_rs2 = 5'd4;
    #1;
    total++; if (ctrl !== C_LU) begin bad++; $display("FAIL mem_drop_lu_ctrl got=%b exp=%b", ctrl, C_LU); end
    step(); exp_stall++;
    clear_inputs();
    #1;
    total++; if (stall_cnt !== exp_stall) begin bad++; $display("FAIL mem_drop_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
  endtask

  task automatic test_freeze_dominance();
    clear_inputs();
    exmem_mem_req = 1'b1; exmem_branch_taken = 1'b1;
    idex_MemRead = 1'b1; idex_rd = 5'd2; ifid_rs1 = 5'd2;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (ctrl !== C_FRZ) begin bad++; $display("FAIL dom_frz%0d_ctrl got=%b exp=%b", i, ctrl, C_FRZ); end
      step(); exp_stall++;
    end
    total++; if (flush_cnt !== exp_flush) begin bad++; $display("FAIL dom_noflush got=%0d exp=%0d", flush_cnt, exp_flush); end
    dmem_ready = 1'b1;
    #1;
    total++; if (ctrl !== C_BR) begin bad++; $display("FAIL dom_release_ctrl got=%b exp=%b", ctrl, C_BR); end
    step(); exp_flush++;
    clear_inputs();
    #1;
    total++; if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin bad++; $display("FAIL dom_cnt got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
  endtask

  task automatic test_timeout();
    clear_inputs();
    exmem_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctrl !== C_FRZ) begin bad++; $display("FAIL to_frz%0d_ctrl got=%b exp=%b", i, ctrl, C_FRZ); end
      step(); exp_stall++;
    end
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL to_early_err got=%b exp=0", mem_error); end
    step(); exp_stall++;
    total++; if (mem_error !== 1'b1) begin bad++; $display("FAIL to_err got=%b exp=1", mem_error); end
    // ready or a branch no longer matter
    dmem_ready = 1'b1; exmem_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (ctrl !== C_FRZ) begin bad++; $display("FAIL to_hold%0d_ctrl got=%b exp=%b", i, ctrl, C_FRZ); end
      step(); exp_stall++;
    end
    exmem_mem_req = 1'b0; exmem_branch_taken = 1'b0;
    #1;
    total++; if (ctrl !== C_FRZ || mem_error !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b/%b exp=%b/1", ctrl, mem_error, C_FRZ); end
    total++; if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin bad++; $display("FAIL to_cnt got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); end
  endtask

  task automatic test_reset_recovery();
    // leave ERROR via reset
    reset = 1'b1;
    #1;
    total++; if (ctrl !== C_RST) begin bad++; $display("FAIL rr_err_ctrl got=%b exp=%b", ctrl, C_RST); end
    step();
    reset = 1'b0;
    clear_inputs();
    #1;
    total++; if (mem_error !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin bad++; $display("FAIL rr_err_state got=%b/%0d/%0d exp=0/0/0", mem_error, stall_cnt, flush_cnt); end
    total++; if (ctrl !== C_DEF) begin bad++; $display("FAIL rr_err_default got=%b exp=%b", ctrl, C_DEF); end
    // reset in the middle of a memory wait
    exmem_mem_req = 1'b1;
    step();
    step();
    reset = 1'b1;
    #1;
    total++; if (ctrl !== C_RST) begin bad++; $display("FAIL rr_wait_ctrl got=%b exp=%b", ctrl, C_RST); end
    step();
    reset = 1'b0;
    exmem_mem_req = 1'b0;
    #1;
    total++; if (stall_cnt !== 0 || ctrl !== C_DEF) begin bad++; $display("FAIL rr_wait_state got=%0d/%b exp=0/%b", stall_cnt, ctrl, C_DEF); end
    // a fresh wait must again take five freeze edges to time out
    exmem_mem_req = 1'b1;
    for (int i = 0; i < 4; i++) step();
    total++; if (mem_error !== 1'b0) begin bad++; $display("FAIL rr_wait_cleared got=%b exp=0", mem_error); end
    step();
    total++; if (mem_error !== 1'b1 || stall_cnt !== 5) begin bad++; $display("FAIL rr_retimeout got=%b/%0d exp=1/5", mem_error, stall_cnt); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    clear_inputs();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_dominance();
    test_timeout();
    test_reset_recovery();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage RV64 pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Generates per-stage write-enable (hold), flush and bubble controls from load-use hazards, taken branches and a variable-latency data-memory handshake.
- Tracks memory wait time with a timeout FSM and keeps performance counters.
- Sits beside the datapath: it reads stage fields and drives pipeline-register enables, flushes and the PC write enable.

Parameters:
- MEM_TIMEOUT, 16: maximum consecutive cycles spent waiting on dmem_ready before an error is declared (legal range 1..255).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- idex_MemRead  in  1  load in EX stage
- idex_rd  in  5  destination register of EX-stage instruction
- ifid_rs1  in  5  rs1 of ID-stage instruction
- ifid_rs2  in  5  rs2 of ID-stage instruction
- exmem_branch_taken  in  1  resolved taken branch/jump in MEM stage
- exmem_mem_req  in  1  MEM-stage instruction accesses data memory (MemRead|MemWrite)
- dmem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- pc_sel_branch  out  1  select branch target for next PC
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_write  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear (control bits to 0)
- exmem_write  out  1  EX/MEM load enable
- exmem_flush  out  1  EX/MEM clear
- memwb_bubble  out  1  force MEM/WB RegWrite/MemtoReg to 0 this edge
- mem_error  out  1  sticky memory-timeout flag
- stall_cnt  out  CNT_W  cycles with any freeze or stall
- flush_cnt  out  CNT_W  number of branch flush events

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. The state, wait counter (8 bit), mem_error and counters are registered. Control outputs are combinational from the current state and inputs (zero latency).
- Reset (synchronous, while reset=1):
  - Controls: all *_write=0, pc_write=0, all *_flush=1, memwb_bubble=1, pc_sel_branch=0.
  - Next state RUN, wait counter 0, mem_error 0, stall_cnt 0, flush_cnt 0.
  - Reset overrides every other condition, including mid-wait and ERROR.
- Defaults (no event): all writes=1, flushes=0, memwb_bubble=0, pc_sel_branch=0.
- Priority: ERROR > memory freeze > branch flush > load-use stall.
- Memory freeze (state RUN or MEM_WAIT, exmem_mem_req=1, dmem_ready=0):
  - pc_write=ifid_write=idex_write=exmem_write=0, memwb_bubble=1, no flushes.
  - Branch and load-use conditions are ignored.
  - RUN->MEM_WAIT with wait counter=1; in MEM_WAIT the counter increments.
  - If a freeze cycle occurs with wait counter==MEM_TIMEOUT, go to ERROR and set mem_error.
- In MEM_WAIT with dmem_ready=1 or exmem_mem_req=0: no freeze this cycle, normal priority evaluation applies, next state RUN, counter 0.
- Dmem_ready=1 in the same cycle as the request in RUN means no freeze and no state change.
- Branch flush (exmem_branch_taken=1, no freeze):
  - ifid_flush=idex_flush=exmem_flush=1, pc_sel_branch=1, pc_write=1, memwb_bubble=0.
  - flush_cnt+1. Any simultaneous load-use stall is discarded.
- Load-use stall (idex_MemRead=1, idex_rd!=0, idex_rd==ifid_rs1 or idex_rd==ifid_rs2):
  - pc_write=0, ifid_write=0, idex_flush=1; EX/MEM and MEM/WB advance normally.
  - Lasts exactly one cycle per hazard, because the flushed ID/EX clears idex_MemRead.
- ERROR: full freeze (all writes 0, memwb_bubble=1) every cycle, mem_error=1; exit only via reset.
- stall_cnt +1 on every cycle with a freeze, a load-use stall or ERROR. Both counters wrap modulo 2^CNT_W and are not incremented during reset.

Test Plan:
- Load-use: idex_MemRead=1, idex_rd=5, ifid_rs2=5 for 1 cycle -> pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_cnt=1; idex_rd=0 with rs1=0 -> no stall.
- Branch: exmem_branch_taken=1 one cycle -> three flushes=1, pc_sel_branch=1, pc_write=1; flush_cnt=1; with a simultaneous load-use hazard -> no stall, pc_write=1.
- Memory wait: exmem_mem_req=1, dmem_ready low 3 cycles then high -> 3 freeze cycles with memwb_bubble=1, 4th cycle normal, state back to RUN, stall_cnt=3.
- Freeze dominance: branch_taken=1 during the freeze -> no flushes until dmem_ready=1, then flush on that release cycle.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> mem_error=1 after the 5th freeze cycle edge, permanent freeze; dmem_ready=1 has no effect.
- Reset mid-MEM_WAIT or in ERROR: assert reset 1 cycle -> flushes=1 during reset; afterwards RUN, mem_error=0, both counters 0, default outputs.
